// File: rtl/emulador_hcsr04_if.sv
// emulador_hcsr04_if: trigger/echo link between the sensor interface (master) and the emulator (slave)
interface emulador_hcsr04_if;
  logic        trigger;
  logic [11:0] distancia;
  logic        echo;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;
  modport master (output trigger, distancia, input echo, ocupado, pronto, db_estado);
  modport slave (input trigger, distancia, output echo, ocupado, pronto, db_estado);
endinterface

// File: rtl/emulador_hcsr04.sv
// emulador_hcsr04: HC-SR04 responder; measures trigger, waits the burst delay, emits an echo sized by distancia
module emulador_hcsr04 #(
  parameter int R           = 2941,
  parameter int LARGURA_MIN = 500,
  parameter int ATRASO      = 10000,
  parameter int ECHO_MAX    = 1900000,
  parameter int INTERVALO   = 500
) (
  input logic clock,
  input logic reset,
  emulador_hcsr04_if.slave s
);
  localparam int WMAX = (400 * R > ECHO_MAX) ? 400 * R : ECHO_MAX;
  localparam int TMAX = (ATRASO > INTERVALO) ? ((ATRASO > LARGURA_MIN) ? ATRASO : LARGURA_MIN)
                                             : ((INTERVALO > LARGURA_MIN) ? INTERVALO : LARGURA_MIN);
  localparam int CW = $clog2(((WMAX > TMAX) ? WMAX : TMAX) + 1);
  localparam logic [3:0] INICIAL      = 4'd0;
  localparam logic [3:0] ESPERA       = 4'd1;
  localparam logic [3:0] MEDE_TRIGGER = 4'd2;
  localparam logic [3:0] ATRASO_ST    = 4'd3;
  localparam logic [3:0] ECHO_ALTO    = 4'd4;
  localparam logic [3:0] FIM          = 4'd5;
  localparam logic [3:0] HOLDOFF      = 4'd6;
  logic          trig_m, trig_s;
  logic [3:0]    estado;
  logic [CW-1:0] cnt, largura, largura_calc;
  logic          echo, ocupado, pronto;
  logic [3:0]    cen, dez, uni;
  logic [10:0]   d_bin;
  logic          valido;
  assign cen = s.distancia[11:8];
  assign dez = s.distancia[7:4];
  assign uni = s.distancia[3:0];
  assign d_bin = 11'(cen) * 11'd100 + 11'(dez) * 11'd10 + 11'(uni);
  assign valido = cen <= 4'd9 && dez <= 4'd9 && uni <= 4'd9 && d_bin != 11'd0 && d_bin <= 11'd400;
  assign largura_calc = valido ? CW'(32'(d_bin) * R) : CW'(ECHO_MAX);
  always_ff @(posedge clock or negedge reset)
    if (!reset) {trig_m, trig_s} <= 2'b00;
    else {trig_m, trig_s} <= {s.trigger, trig_m};
  // cnt is shared: trigger width, burst delay, echo width and holdoff never overlap
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado  <= INICIAL;
      cnt     <= '0;
      largura <= '0;
      echo    <= 1'b0;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      case (estado)
        INICIAL: estado <= ESPERA;
        ESPERA: if (trig_s) begin
          estado <= MEDE_TRIGGER;
          cnt    <= CW'(1);
        end
        MEDE_TRIGGER:
          if (trig_s) cnt <= (cnt >= CW'(LARGURA_MIN)) ? cnt : cnt + 1'b1;
          else if (cnt >= CW'(LARGURA_MIN)) begin
            estado  <= ATRASO_ST;
            cnt     <= '0;
            largura <= largura_calc;
            ocupado <= 1'b1;
          end else estado <= ESPERA;
        ATRASO_ST:
          if (cnt == CW'(ATRASO - 1)) begin
            estado <= ECHO_ALTO;
            cnt    <= '0;
            echo   <= 1'b1;
          end else cnt <= cnt + 1'b1;
        ECHO_ALTO:
          if (cnt == largura - 1'b1) begin
            estado <= FIM;
            cnt    <= '0;
            echo   <= 1'b0;
            pronto <= 1'b1;
          end else cnt <= cnt + 1'b1;
        FIM: begin
          estado <= HOLDOFF;
          pronto <= 1'b0;
        end
        HOLDOFF:
          if (cnt == CW'(INTERVALO - 1)) begin
            estado  <= ESPERA;
            cnt     <= '0;
            ocupado <= 1'b0;
          end else cnt <= cnt + 1'b1;
        default: estado <= INICIAL;
      endcase
    end
  assign s.echo      = echo;
  assign s.ocupado   = ocupado;
  assign s.pronto    = pronto;
  assign s.db_estado = estado;
endmodule

// File: tb/tb_emulador_hcsr04.sv
// tb_emulador_hcsr04: directed and random trigger/echo transactions checked against a distance-to-width model
module tb_emulador_hcsr04;
  localparam int R = 4, LMIN = 5, ATRASO = 8, ECHO_MAX = 50, INTERVALO = 6;
  logic clock = 1'b0;
  logic reset;
  int checks = 0, errors = 0;
  emulador_hcsr04_if bus ();
  emulador_hcsr04 #(.R(R), .LARGURA_MIN(LMIN), .ATRASO(ATRASO), .ECHO_MAX(ECHO_MAX),
                    .INTERVALO(INTERVALO)) dut (.clock(clock), .reset(reset), .s(bus));
  always #5 clock = ~clock;
  function automatic int w_ref(input logic [11:0] d);
    int h, t, u, v;
    h = int'(d[11:8]);
    t = int'(d[7:4]);
    u = int'(d[3:0]);
    v = h * 100 + t * 10 + u;
    if (h > 9 || t > 9 || u > 9 || v < 1 || v > 400) return ECHO_MAX;
    return v * R;
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // one full transaction; mexe disturbs distancia during the delay and re-triggers during the echo
  task automatic transacao(input logic [11:0] d, input int hi, input bit mexe);
    int n, a, w, h;
    bit viu, aceita;
    aceita = hi >= LMIN;
    bus.distancia = d;
    bus.trigger = 1'b1;
    repeat (hi) @(negedge clock);
    bus.trigger = 1'b0;
    n = 0;
    viu = 1'b0;
    while (!bus.ocupado && n < 12) begin
      @(negedge clock);
      n++;
      viu |= bus.echo;
    end
    chk("aceite", int'(bus.ocupado), int'(aceita));
    if (!aceita) begin
      chk("sem_echo", int'(viu), 0);
      chk("volta_espera", int'(bus.db_estado), 1);
      return;
    end
    a = 0;
    while (bus.ocupado && !bus.echo && a < 100) begin
      if (mexe && a == 2) bus.distancia = 12'h399;
      @(negedge clock);
      a++;
    end
    chk("atraso", a, ATRASO);
    w = 0;
    while (bus.echo && w < 5000) begin
      if (mexe && w == 5) bus.trigger = 1'b1;
      if (mexe && w == 11) bus.trigger = 1'b0;
      @(negedge clock);
      w++;
    end
    chk("largura_echo", w, w_ref(d));
    chk("pronto", int'(bus.pronto), 1);
    chk("ocupado_fim", int'(bus.ocupado), 1);
    @(negedge clock);
    chk("pronto_unico", int'(bus.pronto), 0);
    h = 0;
    while (bus.ocupado && h < 100) begin
      @(negedge clock);
      h++;
    end
    chk("holdoff", h, INTERVALO);
    chk("estado_espera", int'(bus.db_estado), 1);
    if (mexe) begin
      viu = 1'b0;
      repeat (20) begin
        @(negedge clock);
        viu |= bus.echo | bus.ocupado;
      end
      chk("sem_segundo_echo", int'(viu), 0);
    end
  endtask
  initial begin
    int n;
    logic [11:0] d;
    reset = 1'b0;
    bus.trigger = 1'b0;
    bus.distancia = 12'h000;
    repeat (3) @(negedge clock);
    chk("rst_echo", int'(bus.echo), 0);
    chk("rst_ocupado", int'(bus.ocupado), 0);
    chk("rst_pronto", int'(bus.pronto), 0);
    chk("rst_estado", int'(bus.db_estado), 0);
    reset = 1'b1;
    @(negedge clock);
    chk("pos_rst_estado", int'(bus.db_estado), 1);
    transacao(12'h012, 6, 1'b0);
    transacao(12'h400, 6, 1'b0);
    transacao(12'h401, 6, 1'b0);
    transacao(12'h000, 6, 1'b0);
    transacao(12'h0A3, 6, 1'b0);
    transacao(12'h012, 4, 1'b0);
    transacao(12'h025, 5, 1'b0);
    transacao(12'h012, 6, 1'b1);
    bus.distancia = 12'h020;
    bus.trigger = 1'b1;
    repeat (6) @(negedge clock);
    bus.trigger = 1'b0;
    n = 0;
    while (!bus.echo && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("echo_antes_reset", int'(bus.echo), 1);
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("reset_async_echo", int'(bus.echo), 0);
    chk("reset_async_ocupado", int'(bus.ocupado), 0);
    chk("reset_async_estado", int'(bus.db_estado), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("pos_reset2_estado", int'(bus.db_estado), 1);
    transacao(12'h012, 6, 1'b0);
    for (int i = 0; i < 8; i++) begin
      d = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 10)), 4'($urandom_range(0, 10))};
      transacao(d, int'($urandom_range(3, 8)), 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
